// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch slice.
//   ADDR_W        : byte-address width of the ICache port (PC wraps modulo 2**ADDR_W)
//   INSTR_W       : instruction width
//   PC_STEP       : byte increment between sequential fetches
//   fetch_entry_t : one buffered fetch result {pc, instr}
package fetch_pkg;

  localparam int ADDR_W  = 9;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Bundles the ICache port, the redirect input and the decode-side
// valid/ready stream of the fetch sequencer.
//   master : the fetch sequencer (drives ICache address and decode stream)
//   slave  : the surroundings (ICache data, branch redirect, decode ready)
interface fetch_if;
  import fetch_pkg::*;

  logic [ADDR_W-1:0]  icache_addr;
  logic [INSTR_W-1:0] icache_instr;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;

  modport master (
    output icache_addr,
    input  icache_instr,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  modport slave (
    input  icache_addr,
    output icache_instr,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );

endinterface

// File: rtl/fetch_queue.sv
// Q_DEPTH-entry synchronous FIFO of fetch_entry_t.
//   clk, reset : clock, synchronous active-high reset (pointers and count only)
//   push, din  : enqueue din at the edge
//   pop        : drop the head at the edge (caller guarantees non-empty)
//   flush      : empty the queue at the edge; takes priority over push
//   occ        : number of valid entries
//   head       : oldest entry (meaningful only when occ != 0)
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int Q_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_entry_t                 din,
  output logic [$clog2(Q_DEPTH+1)-1:0] occ,
  output fetch_entry_t                 head
);

  localparam int OCC_W = $clog2(Q_DEPTH + 1);
  localparam int PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;

  fetch_entry_t      mem [Q_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  // Wrap explicitly so non-power-of-two depths also work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(Q_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      occ <= occ + OCC_W'(push) - OCC_W'(pop);
    end
  end

  // Storage carries no reset; validity is tracked by occ alone.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer in front of a 1-cycle registered ICache.
// Owns the fetch PC, tracks the single in-flight read and buffers returned
// instructions in a small queue toward decode. Redirects flush everything
// and restart fetch at the new (word-aligned) PC.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fetch_if.master -- ICache address/data, redirect, decode stream
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                Q_DEPTH  = 2
) (
  input  logic     clk,
  input  logic     reset,
  fetch_if.master  bus
);

  localparam int OCC_W = $clog2(Q_DEPTH + 1);
  localparam int CRD_W = OCC_W + 1;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] rd_pc_q;
  logic              req_q;

  logic [OCC_W-1:0]  occ;
  fetch_entry_t      head;
  fetch_entry_t      ret_entry;
  logic              deq;
  logic              issue;
  logic              push;
  logic [CRD_W-1:0]  credit;

  assign bus.out_valid = (occ != '0);
  assign deq           = bus.out_valid && bus.out_ready;

  // Credit = slots already promised (buffered + in flight) after this
  // cycle's dequeue; a new read is launched only if one slot remains.
  assign credit = CRD_W'(occ) + CRD_W'(req_q) - CRD_W'(deq);
  assign issue  = !bus.redirect_valid && (credit < CRD_W'(Q_DEPTH));

  // Stage: address issue -- ICache samples pc_q at this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      req_q <= 1'b0;
    end else if (bus.redirect_valid) begin
      pc_q  <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
      req_q <= 1'b0;
    end else begin
      req_q <= issue;
      if (issue) pc_q <= pc_q + ADDR_W'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (issue) rd_pc_q <= pc_q;
  end

  assign bus.icache_addr = pc_q;

  // Stage: data return -- read data is valid while req_q is high and is
  // enqueued at the next edge unless a redirect drops it.
  assign push      = req_q && !bus.redirect_valid;
  assign ret_entry = '{pc: rd_pc_q, instr: bus.icache_instr};

  fetch_queue #(
    .Q_DEPTH (Q_DEPTH)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (deq),
    .flush (bus.redirect_valid),
    .din   (ret_entry),
    .occ   (occ),
    .head  (head)
  );

  // Idle outputs read as zero so stale storage never leaks toward decode.
  assign bus.out_instr = bus.out_valid ? head.instr : '0;
  assign bus.out_pc    = bus.out_valid ? head.pc    : '0;

  a_credit_range : assert property (@(posedge clk) disable iff (reset)
    (CRD_W'(occ) + CRD_W'(req_q)) <= CRD_W'(Q_DEPTH));

  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(push && !deq && (occ == OCC_W'(Q_DEPTH))));

endmodule
